// File: rtl/motors_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motors_cmd_issuer: pen-move command to MotorsCtrl pulse/servo transactions |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module motors_cmd_issuer #(
  parameter int PULSE_NUM_X_BITS = 16,
  parameter int PULSE_NUM_Y_BITS = 16,
  parameter int POS_BITS         = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        cmd_valid,
  output logic                        cmd_rdy,
  input  logic [POS_BITS-1:0]         cmd_x,
  input  logic [POS_BITS-1:0]         cmd_y,
  input  logic                        cmd_rel,
  input  logic                        cmd_servo,
  input  logic                        home,
  output logic                        cmd_err,
  output logic                        busy,
  output logic [POS_BITS-1:0]         cur_x,
  output logic [POS_BITS-1:0]         cur_y,
  output logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
  output logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
  output logic                        servo_pos,
  output logic                        trigger,
  input  logic                        rdy
);

  localparam logic c_servo_up = 1'b0;

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_calc       = 3'd1;
  localparam logic [2:0] c_st_servo_trig = 3'd2;
  localparam logic [2:0] c_st_servo_wait = 3'd3;
  localparam logic [2:0] c_st_move_trig  = 3'd4;
  localparam logic [2:0] c_st_move_wait  = 3'd5;

  // Symmetric pulse range: the most negative code is never issued.
  localparam logic [POS_BITS:0] c_max_x = {{(POS_BITS+2-PULSE_NUM_X_BITS){1'b0}}, {(PULSE_NUM_X_BITS-1){1'b1}}};
  localparam logic [POS_BITS:0] c_min_x = {{(POS_BITS+2-PULSE_NUM_X_BITS){1'b1}}, {(PULSE_NUM_X_BITS-2){1'b0}}, 1'b1};
  localparam logic [POS_BITS:0] c_max_y = {{(POS_BITS+2-PULSE_NUM_Y_BITS){1'b0}}, {(PULSE_NUM_Y_BITS-1){1'b1}}};
  localparam logic [POS_BITS:0] c_min_y = {{(POS_BITS+2-PULSE_NUM_Y_BITS){1'b1}}, {(PULSE_NUM_Y_BITS-2){1'b0}}, 1'b1};

  logic [2:0]          r_state;
  logic [POS_BITS-1:0] r_cmd_x;
  logic [POS_BITS-1:0] r_cmd_y;
  logic                r_cmd_rel;
  logic                r_cmd_servo;
  logic [POS_BITS:0]   r_dx;
  logic [POS_BITS:0]   r_dy;
  logic [POS_BITS-1:0] r_new_x;
  logic [POS_BITS-1:0] r_new_y;

  logic [POS_BITS:0]   w_dx;
  logic [POS_BITS:0]   w_dy;
  logic [POS_BITS:0]   w_new_x;
  logic [POS_BITS:0]   w_new_y;
  logic                w_bad;
  logic                w_zero;

  assign w_dx = r_cmd_rel ? {r_cmd_x[POS_BITS-1], r_cmd_x}
                          : {r_cmd_x[POS_BITS-1], r_cmd_x} - {cur_x[POS_BITS-1], cur_x};
  assign w_dy = r_cmd_rel ? {r_cmd_y[POS_BITS-1], r_cmd_y}
                          : {r_cmd_y[POS_BITS-1], r_cmd_y} - {cur_y[POS_BITS-1], cur_y};
  // cur + dx equals the target for absolute moves, so one overflow check covers both
  assign w_new_x = {cur_x[POS_BITS-1], cur_x} + w_dx;
  assign w_new_y = {cur_y[POS_BITS-1], cur_y} + w_dy;

  assign w_bad = ($signed(w_dx) > $signed(c_max_x)) || ($signed(w_dx) < $signed(c_min_x)) ||
                 ($signed(w_dy) > $signed(c_max_y)) || ($signed(w_dy) < $signed(c_min_y)) ||
                 (w_new_x[POS_BITS] != w_new_x[POS_BITS-1]) ||
                 (w_new_y[POS_BITS] != w_new_y[POS_BITS-1]);
  assign w_zero = (w_dx == '0) && (w_dy == '0);

  assign busy = (r_state != c_st_idle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_cmd_x     <= '0;
      r_cmd_y     <= '0;
      r_cmd_rel   <= 1'b0;
      r_cmd_servo <= c_servo_up;
      r_dx        <= '0;
      r_dy        <= '0;
      r_new_x     <= '0;
      r_new_y     <= '0;
      cmd_rdy     <= 1'b0;
      cmd_err     <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      pulse_num_x <= '0;
      pulse_num_y <= '0;
      servo_pos   <= c_servo_up;
      trigger     <= 1'b0;
    end else if (clk_en) begin
      cmd_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (cmd_valid && cmd_rdy) begin
            r_cmd_x     <= cmd_x;
            r_cmd_y     <= cmd_y;
            r_cmd_rel   <= cmd_rel;
            r_cmd_servo <= cmd_servo;
            cmd_rdy     <= 1'b0;
            r_state     <= c_st_calc;
          end else begin
            cmd_rdy <= 1'b1;
            if (home) begin
              cur_x <= '0;
              cur_y <= '0;
            end
          end
        end
        c_st_calc: begin
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_new_x <= w_new_x[POS_BITS-1:0];
          r_new_y <= w_new_y[POS_BITS-1:0];
          if (w_bad) begin
            cmd_err <= 1'b1;
            cmd_rdy <= 1'b1;
            r_state <= c_st_idle;
          end else if (r_cmd_servo != servo_pos) begin
            pulse_num_x <= '0;
            pulse_num_y <= '0;
            servo_pos   <= r_cmd_servo;
            trigger     <= 1'b1;
            r_state     <= c_st_servo_trig;
          end else if (w_zero) begin
            cmd_rdy <= 1'b1;
            r_state <= c_st_idle;
          end else begin
            pulse_num_x <= w_dx[PULSE_NUM_X_BITS-1:0];
            pulse_num_y <= w_dy[PULSE_NUM_Y_BITS-1:0];
            trigger     <= 1'b1;
            r_state     <= c_st_move_trig;
          end
        end
        c_st_servo_trig: begin
          if (!rdy) begin
            trigger <= 1'b0;
            r_state <= c_st_servo_wait;
          end
        end
        c_st_servo_wait: begin
          if (rdy) begin
            if ((|r_dx) || (|r_dy)) begin
              pulse_num_x <= r_dx[PULSE_NUM_X_BITS-1:0];
              pulse_num_y <= r_dy[PULSE_NUM_Y_BITS-1:0];
              trigger     <= 1'b1;
              r_state     <= c_st_move_trig;
            end else begin
              cmd_rdy <= 1'b1;
              r_state <= c_st_idle;
            end
          end
        end
        c_st_move_trig: begin
          if (!rdy) begin
            trigger <= 1'b0;
            r_state <= c_st_move_wait;
          end
        end
        c_st_move_wait: begin
          if (rdy) begin
            cur_x   <= r_new_x;
            cur_y   <= r_new_y;
            cmd_rdy <= 1'b1;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/motors_cmd_issuer.md
Name: motors_cmd_issuer

Overview:
- Master side of MotorsCtrl_IF.
- Accepts absolute or relative pen-move commands over a valid/ready port and tracks the current pen position.
- Converts each command into signed per-axis pulse counts and drives the trigger/rdy handshake into MotorsCtrl.
- Sits between the G-code/command decoder and MotorsCtrl; servo changes are issued as a separate transaction before any motion.

Parameters:
- PULSE_NUM_X_BITS, 16: signed width of intf.pulse_num_x.
- PULSE_NUM_Y_BITS, 16: signed width of intf.pulse_num_y.
- POS_BITS, 20: signed width of the tracked absolute position and of the command coordinates.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- clk_en  in  1  state/handshake advance enable; all logic holds when low
- cmd_valid  in  1  command present
- cmd_rdy  out  1  command accepted when cmd_valid&&cmd_rdy&&clk_en
- cmd_x  in  POS_BITS  signed target X (absolute) or delta X (relative)
- cmd_y  in  POS_BITS  signed target Y or delta Y
- cmd_rel  in  1  1 = relative command
- cmd_servo  in  1  requested pen position (Servo_PKG SERVO_POS_UP/SERVO_POS_DOWN)
- home  in  1  sync clear of the position, honoured only in IDLE
- cmd_err  out  1  one-cycle pulse: command rejected
- busy  out  1  high in any state except IDLE
- cur_x  out  POS_BITS  tracked X position
- cur_y  out  POS_BITS  tracked Y position
- intf  MotorsCtrl_IF.master  -  pulse_num_x, pulse_num_y, servo_pos, trigger (out); rdy (in)

Behaviour:
- Reset values:
  - cmd_rdy=0, cmd_err=0, busy=0.
  - cur_x=cur_y=0.
  - pulse_num_x=pulse_num_y=0, servo_pos=SERVO_POS_UP, trigger=0.
  - State IDLE. cmd_rdy becomes 1 on the first enabled cycle after reset deasserts.
- Reset is asynchronous mid-transaction: trigger drops immediately. MotorsCtrl is reset by the same signal.
- IDLE:
  - cmd_rdy=1.
  - On accept, latch the command, drop cmd_rdy, and go to CALC.
  - home=1 with no accept: cur_x=cur_y=0 next cycle.
  - home and an accept in the same cycle: the accept takes priority and home is ignored.
- CALC (1 cycle):
  - dx = cmd_rel ? cmd_x : cmd_x - cur_x; dy likewise. Computed at POS_BITS+1 width.
  - If dx is outside [-(2^(PULSE_NUM_X_BITS-1)-1), 2^(PULSE_NUM_X_BITS-1)-1], or dy is out of its range, or the new position overflows POS_BITS:
    - pulse cmd_err; position is unchanged; go to IDLE.
  - Else if cmd_servo differs from the current servo_pos: go to SERVO_TRIG.
  - Else if dx==0 and dy==0: go to IDLE (no transaction).
  - Else: go to MOVE_TRIG.
- SERVO_TRIG:
  - Drive pulse_num_x=pulse_num_y=0, servo_pos=cmd_servo, trigger=1.
  - When rdy is sampled 0, trigger<=0 and go to SERVO_WAIT.
- SERVO_WAIT:
  - On rdy sampled 1: if dx|dy is nonzero go to MOVE_TRIG, else go to IDLE.
- MOVE_TRIG:
  - Drive pulse_num_x=dx, pulse_num_y=dy, servo_pos unchanged, trigger=1.
  - When rdy is sampled 0, trigger<=0 and go to MOVE_WAIT.
- MOVE_WAIT:
  - On rdy sampled 1: cur_x+=dx, cur_y+=dy (same cycle), go to IDLE.
- Operand stability:
  - pulse_num_*/servo_pos are stable from trigger rise until rdy returns high.
  - Operands retain their last values in IDLE.
- Latency with clk_en=1 and rdy already high:
  - accept at cycle N, trigger high at N+2.
  - After the final rdy rise at cycle M, cmd_rdy is high at M+1.
- Unexpected rdy:
  - rdy already 0 when entering a *_TRIG state is treated as the acknowledge.
  - rdy rising while in a *_TRIG state is ignored.
- The servo-only transaction is always issued before motion, never combined with it.

Test Plan:
- Reset held then released, no cmd -> all outputs at reset values; cmd_rdy=1 one cycle after release; trigger stays 0.
- Absolute cmd (x=-3, y=2, DOWN) from (0,0) with a model slave -> one servo transaction (0,0,DOWN), then one move (-3,2,DOWN); cur=(-3,2); trigger drops on each rdy fall.
- Relative cmd (x=5, y=1, UP) from (-3,2) -> servo transaction UP, then move (5,1); cur=(2,3); no cmd_err.
- Absolute cmd equal to the current position with the same servo -> no trigger; cmd_rdy returns 2 cycles after accept.
- Relative cmd x=2^15 (PULSE_NUM_X_BITS=16) -> cmd_err pulses for 1 cycle; no trigger; cur unchanged.
- Reset asserted during MOVE_WAIT -> trigger=0 immediately; cur=(0,0); a new command afterwards completes normally. Also toggle clk_en low mid-handshake -> the state freezes and the transaction completes once clk_en returns high.
